// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode classes, instruction formats and immediate limits shared by the encoder
package riscv_pkg;
  typedef enum logic [1:0] {FMT_I, FMT_S, FMT_R, FMT_SB} fmt_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
  localparam logic signed [63:0] IMM12_MAX = 64'sd2047;
  localparam logic signed [63:0] IMM13_MIN = -64'sd4096;
  localparam logic signed [63:0] IMM13_MAX = 64'sd4094;
  function automatic fmt_t fmt_of(input logic [6:0] op);
    return op[6] ? FMT_SB : op[5] ? (op[4] ? FMT_R : FMT_S) : FMT_I;
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: selects the format from the opcode, packs the 32-bit word and range-checks imm
module instr_pack
  import riscv_pkg::*;
(
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic signed [63:0] imm,
  output logic [31:0]        word,
  output logic               err
);
  fmt_t fmt;
  logic in12, in13;
  always_comb begin
    fmt  = fmt_of(opcode);
    in12 = imm >= IMM12_MIN && imm <= IMM12_MAX;
    in13 = imm >= IMM13_MIN && imm <= IMM13_MAX && !imm[0];
    word = fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
           fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
           fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode} :
                          {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    err  = fmt == FMT_R ? 1'b0 : fmt == FMT_SB ? !in13 : !in12;
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: encodes a field bundle and writes it little-endian, one byte per cycle, to memory
module instr_mem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              imm_err,
  output logic              full,
  output logic [31:0]       instr
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'((1 << ADDR_W) - 4);
  logic [0:0]      state;
  logic [1:0]      k;
  logic [ADDR_W:0] ptr;
  logic [31:0]     word;
  logic            err, fire;
  instr_pack u_pack (
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .word   (word),
    .err    (err)
  );
  always_comb begin
    full      = ptr > LIMIT;
    in_ready  = state == IDLE && !full && !reset;
    fire      = in_valid && in_ready;
    mem_we    = state == WRITE;
    mem_addr  = ptr[ADDR_W-1:0];
    mem_wdata = instr[{k, 3'b000} +: 8];
    done      = mem_we && k == 2'd3;
  end
  // pointer is one bit wider than the address so it saturates at full instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      ptr     <= (ADDR_W+1)'(BASE_ADDR);
      instr   <= '0;
      imm_err <= 1'b0;
    end else begin
      imm_err <= fire && err;
      if (fire && !err) begin
        state <= WRITE;
        k     <= '0;
        instr <= word;
      end else if (state == WRITE) begin
        ptr <= ptr + 1'b1;
        k   <= k + 1'b1;
        if (k == 2'd3) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scoreboard bench for the encoder/loader on a 16-byte memory
module tb_instr_mem_loader;
  import riscv_pkg::*;
  typedef struct packed {logic [3:0] a; logic [7:0] d; logic dn;} wr_t;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [63:0] imm;
  logic        mem_we, done, imm_err, full;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] instr;
  wr_t         exp_q[$];
  wr_t         e;
  int          n_assert = 0, n_fail = 0, ptr_model = 0;
  instr_mem_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .imm_err(imm_err), .full(full), .instr(instr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] imm_gen(input logic [31:0] i);
    return i[6] ? {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           i[5:4] == 2'b10 ? {{52{i[31]}}, i[31:25], i[11:7]} : {{52{i[31]}}, i[31:20]};
  endfunction
  task automatic send(input logic [6:0] op, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [63:0] im, input int nb, input logic [31:0] w);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", in_ready, 1);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
    for (int i = 0; i < nb; i++) exp_q.push_back('{4'(ptr_model + i), w[8*i +: 8], i == 3});
    ptr_model += nb;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask
  always @(negedge clk) if (mem_we) begin
    if (exp_q.size() == 0) chk("unexp_we", mem_we, 0);
    else begin
      e = exp_q.pop_front();
      chk("addr", mem_addr, e.a);
      chk("data", mem_wdata, e.d);
      chk("done", done, e.dn);
    end
  end
  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", imm_err, 0);
    chk("rst_full", full, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ready", in_ready, 1);
    send(OPC_LOAD, 1, 2, 0, 3, 0, -64'sd8, 4, 32'hFF813083);
    drain();
    chk("instr_ld", instr, 32'hFF813083);
    chk("rt_ld", imm_gen(instr), -64'sd8);
    send(OPC_STORE, 0, 2, 5, 3, 0, 64'sd16, 4, 32'h00513823);
    drain();
    chk("instr_sd", instr, 32'h00513823);
    chk("rt_sd", imm_gen(instr), 64'sd16);
    send(OPC_BRANCH, 0, 1, 2, 0, 0, -64'sd4, 4, 32'hFE208EE3);
    drain();
    chk("instr_beq", instr, 32'hFE208EE3);
    chk("rt_beq", imm_gen(instr), -64'sd4);
    @(negedge clk);
    chk("full_before", full, 0);
    send(OPC_LOAD, 1, 2, 0, 3, 0, 64'sd2048, 0, 0);
    @(negedge clk);
    chk("err_i2048", imm_err, 1);
    chk("ready_after_err", in_ready, 1);
    chk("instr_kept", instr, 32'hFE208EE3);
    send(OPC_BRANCH, 0, 1, 2, 0, 0, 64'sd3, 0, 0);
    @(negedge clk);
    chk("err_sb3", imm_err, 1);
    @(negedge clk);
    chk("err_pulse_end", imm_err, 0);
    send(OPC_BRANCH, 0, 1, 2, 1, 0, -64'sd4096, 4, 32'h80209063);
    drain();
    chk("instr_sbmin", instr, 32'h80209063);
    chk("rt_sbmin", imm_gen(instr), -64'sd4096);
    chk("err_sbmin", imm_err, 0);
    @(negedge clk);
    chk("full_set", full, 1);
    chk("ready_full", in_ready, 0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ignored_err", imm_err, 0);
    chk("ignored_instr", instr, 32'h80209063);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr_model = 0;
    chk("full_cleared", full, 0);
    chk("instr_cleared", instr, 0);
    send(OPC_LOAD, 1, 2, 0, 3, 0, -64'sd8, 2, 32'hFF813083);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", mem_we, 0);
    reset = 1'b0;
    ptr_model = 0;
    @(negedge clk);
    chk("ready_post_abort", in_ready, 1);
    chk("abort_drain", exp_q.size(), 0);
    send(OPC_OP, 3, 1, 2, 0, 7'h20, 64'h7FFF_FFFF_FFFF_FFFF, 4, 32'h402081B3);
    @(negedge clk);
    chk("r_no_err", imm_err, 0);
    drain();
    chk("instr_r", instr, 32'h402081B3);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Sequential instruction encoder and loader: accepts decoded RISC-V instruction fields plus a 64-bit signed immediate and packs them into a 32-bit I/S/R/SB-format word. It range-checks the immediate, then writes the word little-endian, one byte per cycle, into the byte-wide instruction memory at an auto-incrementing address. It is the inverse of the core's immediate generator and is used by the test harness and boot path to populate instruction memory.

## Interface
- ADDR_W, 8: instruction-memory byte address width.
- BASE_ADDR, 0: first byte address written after reset; must be a multiple of 4.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- opcode  in  7  instruction opcode.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3;  funct7  in  7  function fields.
- imm  in  64  signed immediate (byte offset for SB).
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- done  out  1  one-cycle pulse with the 4th byte write.
- imm_err  out  1  one-cycle pulse: bundle rejected.
- full  out  1  fewer than 4 bytes of memory remain.
- instr  out  32  last successfully encoded word.

## Operation
- Format select from opcode. [6:5]=00 selects I-type. [6:5]=01 with opcode[4]=0 selects S-type. [6:5]=01 with opcode[4]=1 selects R-type. opcode[6]=1 selects SB-type.
- Packing:
  - I-type: {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - R-type: {funct7, rs2, rs1, funct3, rd, opcode}; imm is ignored.
  - SB-type: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Range rules:
  - I/S: -2048 ≤ imm ≤ 2047.
  - SB: -4096 ≤ imm ≤ 4094 and imm[0]=0.
  - R: never errors.
  - Comparison is on the full 64-bit signed value.
- Round-trip requirement: the immediate generator applied to instr returns imm exactly, for every accepted I/S/SB bundle.
- FSM states:
  - IDLE: in_ready = ~full & ~reset.
  - WRITE: byte index k runs 0..3.
- Transitions:
  - IDLE, handshake, in range: latch instr; go to WRITE with k=0.
  - IDLE, handshake, out of range: imm_err pulses next cycle; no write; pointer and instr unchanged; stay in IDLE.
  - WRITE: mem_we=1, mem_addr=ptr, mem_wdata=instr[8k+7:8k]; ptr++. At k=3, done=1 and go to IDLE.
- Pointer is ADDR_W+1 bits wide. full = (ptr > 2^ADDR_W − 4). It never wraps; only reset clears it.
- Reset values: state IDLE, ptr=BASE_ADDR, instr=0, and mem_we/done/imm_err/full=0. in_ready=0 while reset is high.
- Reset mid-WRITE aborts the sequence. Bytes already written stay in memory; there is no further mem_we.

## Timing
- Accept on the edge where in_valid & in_ready. Bytes are written in the 4 following cycles; done coincides with byte 3.
- Throughput: one instruction per 5 cycles. in_ready is low throughout WRITE.
- imm_err asserts exactly 1 cycle after the rejecting handshake. in_ready stays high, so back-to-back bundles are allowed.
- full updates in the cycle after the final byte write. The bundle in flight always completes.
- mem_addr/mem_wdata are don't-care when mem_we=0.

## Structure
- Shared package riscv_pkg holds:
  - opcode class constants;
  - format enum FMT_I/FMT_S/FMT_R/FMT_SB;
  - immediate limit constants IMM12_MIN/MAX and IMM13_MIN/MAX.
- Sub-module instr_pack (combinational) performs format select, packing and the range check, producing {word, err}. instr_mem_loader contains the FSM, pointer and byte serializer.

## Test plan
- I-type ld (opcode 0000011, rd=1, rs1=2, funct3=3, imm=-8) after reset -> instr=0xFF813083; bytes 83,30,81,FF at addr 0..3; done with the last byte.
- S-type sd (opcode 0100011, rs1=2, rs2=5, funct3=3, imm=16) next -> instr=0x00513823; bytes 23,38,51,00 at addr 4..7.
- SB-type beq (opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-4) -> instr=0xFE208EE3. Passing it through the immediate generator returns -4.
- Range errors:
  - I-type imm=2048 -> imm_err pulse; no mem_we; ptr unchanged.
  - SB-type imm=3 -> imm_err pulse.
  - SB-type imm=-4096 -> accepted.
- Fill with ADDR_W=4: four valid bundles -> 16 writes, then full=1 and in_ready=0. A 5th in_valid is ignored. Reset -> full=0, next write at addr 0.
- Reset asserted in the cycle of byte 1 -> mem_we=0 from the next cycle. in_ready=1 the cycle after reset deasserts. The next bundle writes at BASE_ADDR.
